// File: rtl/csp_stage_sequencer.sv
// rtl/csp_stage_sequencer.sv - CSP pass sequencer: CBS pair, residual chain, output CBS, result handshake.
// Optional CSP_SEQ_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module csp_stage_sequencer #(
  parameter int NUM_RES  = 3,
  parameter int LAT_CBS  = 8,
  parameter int LAT_RES  = 12,
  parameter int LAT_CBSO = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               start_ready,
  input  logic               abort,
  output logic               cbs_go,
  output logic [NUM_RES-1:0] res_go,
  output logic               cbso_go,
  output logic [3:0]         res_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
`ifdef CSP_SEQ_PERF_EN
  ,
  output logic [15:0]        perf_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CBS, S_RES, S_CBSO, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_CBS  = CNT_W'(LAT_CBS - 1);
  localparam logic [CNT_W-1:0] CNT_RES  = CNT_W'(LAT_RES - 1);
  localparam logic [CNT_W-1:0] CNT_CBSO = CNT_W'(LAT_CBSO - 1);
  localparam logic [3:0]       LAST_RES = 4'(NUM_RES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         res_idx_q, res_idx_d;
  logic               cbs_go_q, cbs_go_d;
  logic [NUM_RES-1:0] res_go_q, res_go_d;
  logic               cbso_go_q, cbso_go_d;
  logic               out_valid_q, out_valid_d;
  logic               start_ready_q, start_ready_d;
  logic               busy_q, busy_d;
  logic               res_fire;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_idx_d   = res_idx_q;
    cbs_go_d    = 1'b0;
    cbso_go_d   = 1'b0;
    out_valid_d = out_valid_q;
    res_fire    = 1'b0;
    res_go_d    = '0;

    if (abort) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      res_idx_d   = 4'd0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_CBS;
            cbs_go_d = 1'b1;
            cnt_d    = CNT_CBS;
          end
        end
        S_CBS: begin
          if (cnt_q == '0) begin
            state_d   = S_RES;
            res_idx_d = 4'd0;
            res_fire  = 1'b1;
            cnt_d     = CNT_RES;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_RES: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (res_idx_q < LAST_RES) begin
            res_idx_d = res_idx_q + 4'd1;
            res_fire  = 1'b1;
            cnt_d     = CNT_RES;
          end else begin
            // res_idx reads 0 whenever the residual chain is not running
            state_d   = S_CBSO;
            res_idx_d = 4'd0;
            cbso_go_d = 1'b1;
            cnt_d     = CNT_CBSO;
          end
        end
        S_CBSO: begin
          if (cnt_q == '0) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          res_idx_d   = 4'd0;
          out_valid_d = 1'b0;
        end
      endcase
    end

    for (int i = 0; i < NUM_RES; i++) begin
      res_go_d[i] = res_fire && (res_idx_d == 4'(i));
    end

    start_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      res_idx_q     <= 4'd0;
      cbs_go_q      <= 1'b0;
      res_go_q      <= '0;
      cbso_go_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      res_idx_q     <= res_idx_d;
      cbs_go_q      <= cbs_go_d;
      res_go_q      <= res_go_d;
      cbso_go_q     <= cbso_go_d;
      out_valid_q   <= out_valid_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign cbs_go      = cbs_go_q;
  assign res_go      = res_go_q;
  assign cbso_go     = cbso_go_q;
  assign res_idx     = res_idx_q;
  assign out_valid   = out_valid_q;

`ifdef CSP_SEQ_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Counts every cycle the previous state was busy, so the accept edge itself is not counted
  always_comb begin
    perf_d = perf_q;
    if (abort || (state_q == S_IDLE && start)) begin
      perf_d = 16'd0;
    end else if (busy_q && perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 16'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_csp_stage_sequencer.sv
// tb/tb_csp_stage_sequencer.sv - scoreboard bench: default-latency and unit-latency sequencers.
module tb_csp_stage_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start_a, abort_a, out_ready_a;
  logic       start_ready_a, cbs_go_a, cbso_go_a, out_valid_a, busy_a;
  logic [2:0] res_go_a;
  logic [3:0] res_idx_a;
  logic       start_b, abort_b, out_ready_b;
  logic       start_ready_b, cbs_go_b, cbso_go_b, out_valid_b, busy_b;
  logic [2:0] res_go_b;
  logic [3:0] res_idx_b;
`ifdef CSP_SEQ_PERF_EN
  logic [15:0] perf_a, perf_b;
`endif

  csp_stage_sequencer #(.NUM_RES(3), .LAT_CBS(8), .LAT_RES(12), .LAT_CBSO(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .start_ready(start_ready_a), .abort(abort_a),
    .cbs_go(cbs_go_a), .res_go(res_go_a), .cbso_go(cbso_go_a), .res_idx(res_idx_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a)
`ifdef CSP_SEQ_PERF_EN
    , .perf_cycles(perf_a)
`endif
  );

  csp_stage_sequencer #(.NUM_RES(3), .LAT_CBS(1), .LAT_RES(1), .LAT_CBSO(1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .start_ready(start_ready_b), .abort(abort_b),
    .cbs_go(cbs_go_b), .res_go(res_go_b), .cbso_go(cbso_go_b), .res_idx(res_idx_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b)
`ifdef CSP_SEQ_PERF_EN
    , .perf_cycles(perf_b)
`endif
  );

  // Event codes: 0 cbs_go, 16+i res_go[i], 32 cbso_go, 48 out_valid rising
  typedef struct {
    int code;
    int cyc;
  } evt_t;

  evt_t expq[2][$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(int d, int code, int c);
    evt_t e;
    e.code = code;
    e.cyc  = c;
    expq[d].push_back(e);
  endfunction

  function automatic void push_pass(int d, int e0, int lc, int lr, int lo, bit with_valid);
    push(d, 0, e0);
    for (int i = 0; i < 3; i++) push(d, 16 + i, e0 + lc + i * lr);
    push(d, 32, e0 + lc + 3 * lr);
    if (with_valid) push(d, 48, e0 + lc + 3 * lr + lo);
  endfunction

  function automatic void saw(int d, int code);
    evt_t e;
    if (expq[d].size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event dut%0d: got code %0d at cycle %0d expected none", d, code, cyc);
    end else begin
      e = expq[d].pop_front();
      chk($sformatf("evt_code_dut%0d", d), code, e.code);
      chk($sformatf("evt_cycle_dut%0d_code%0d", d, e.code), cyc, e.cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (cbs_go_a) saw(0, 0);
    for (int i = 0; i < 3; i++) begin
      if (res_go_a[i]) begin
        saw(0, 16 + i);
        chk("res_idx_a_at_go", int'(res_idx_a), i);
      end
    end
    if (cbso_go_a) saw(0, 32);
    if (out_valid_a && !pv_a) saw(0, 48);
    if (cbs_go_a || cbso_go_a || (|res_go_a))
      chk("one_go_a", int'(cbs_go_a) + int'(cbso_go_a) + $countones(res_go_a), 1);
    pv_a <= out_valid_a;

    if (cbs_go_b) saw(1, 0);
    for (int i = 0; i < 3; i++) begin
      if (res_go_b[i]) begin
        saw(1, 16 + i);
        chk("res_idx_b_at_go", int'(res_idx_b), i);
      end
    end
    if (cbso_go_b) saw(1, 32);
    if (out_valid_b && !pv_b) saw(1, 48);
    if (cbs_go_b || cbso_go_b || (|res_go_b))
      chk("one_go_b", int'(cbs_go_b) + int'(cbso_go_b) + $countones(res_go_b), 1);
    pv_b <= out_valid_b;
  end

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_start_ready"}, int'(start_ready_a), 1);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_out_valid"}, int'(out_valid_a), 0);
    chk({tag, "_res_idx"}, int'(res_idx_a), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    start_a = 0; abort_a = 0; out_ready_a = 0;
    start_b = 0; abort_b = 0; out_ready_b = 0;
    repeat (3) @(negedge clk);

    chk_idle_a("rst");
    chk("rst_gos", int'(cbs_go_a) + int'(cbso_go_a) + int'(res_go_a), 0);
    chk("rst_b_start_ready", int'(start_ready_b), 1);
`ifdef CSP_SEQ_PERF_EN
    chk("rst_perf", int'(perf_a), 0);
`endif
    reset = 1'b1;

    // unit latencies: first start after reset release, back-to-back go pulses
    start_b = 1; out_ready_b = 1; e0 = cyc + 1;
    push_pass(1, e0, 1, 1, 1, 1);
    @(negedge clk); start_b = 0;
    wait_to(e0 + 6);
    chk("b_busy_after", int'(busy_b), 0);
    chk("b_start_ready_after", int'(start_ready_b), 1);
    chk("b_out_valid_after", int'(out_valid_b), 0);

    // defaults, out_ready delayed, stray start mid-pass
    start_a = 1; e0 = cyc + 1;
    push_pass(0, e0, 8, 12, 8, 1);
    @(negedge clk); start_a = 0;
    chk("p1_start_ready", int'(start_ready_a), 0);
    chk("p1_busy", int'(busy_a), 1);
    wait_to(e0 + 10); start_a = 1;
    @(negedge clk); start_a = 0;
    wait_to(e0 + 52);
    chk("p1_valid_rise", int'(out_valid_a), 1);
    wait_to(e0 + 54);
    chk("p1_valid_hold", int'(out_valid_a), 1);
    chk("p1_ready_low_hold", int'(start_ready_a), 0);
    out_ready_a = 1;
    @(negedge clk); out_ready_a = 0;
    chk_idle_a("p1_done");
`ifdef CSP_SEQ_PERF_EN
    chk("p1_perf", int'(perf_a), 55);
    repeat (3) @(negedge clk);
    chk("p1_perf_frozen", int'(perf_a), 55);
`endif

    // start held through two passes, out_ready always high
    out_ready_a = 1; start_a = 1; e0 = cyc + 1;
    push_pass(0, e0, 8, 12, 8, 1);
    push_pass(0, e0 + 54, 8, 12, 8, 1);
    @(negedge clk);
`ifdef CSP_SEQ_PERF_EN
    chk("p2_perf_cleared", int'(perf_a), 0);
`endif
    wait_to(e0 + 52);
    chk("p2_valid", int'(out_valid_a), 1);
    @(negedge clk);
    chk("p2_valid_one_cycle", int'(out_valid_a), 0);
    chk("p2_start_ready_back", int'(start_ready_a), 1);
    @(negedge clk);
    chk("p2_restart_busy", int'(busy_a), 1);
    start_a = 0;
    wait_to(e0 + 54 + 53);
    chk("p3_busy_done", int'(busy_a), 0);

    // abort while residual stage 1 runs
    start_a = 1; e0 = cyc + 1;
    push(0, 0, e0); push(0, 16, e0 + 8); push(0, 17, e0 + 20);
    @(negedge clk); start_a = 0;
    wait_to(e0 + 24);
    chk("ab_res_idx", int'(res_idx_a), 1);
    abort_a = 1;
    @(negedge clk); abort_a = 0;
    chk_idle_a("ab");
    repeat (60) @(negedge clk);
    chk("ab_quiet_valid", int'(out_valid_a), 0);
    chk("ab_quiet_busy", int'(busy_a), 0);

    // abort in IDLE blocks a simultaneous start
    abort_a = 1; start_a = 1;
    @(negedge clk); abort_a = 0; start_a = 0;
    chk("ab_idle_busy", int'(busy_a), 0);
    chk("ab_idle_start_ready", int'(start_ready_a), 1);

    start_a = 1; e0 = cyc + 1;
    push_pass(0, e0, 8, 12, 8, 1);
    @(negedge clk); start_a = 0;
    wait_to(e0 + 53);
    chk("ab_restart_done", int'(busy_a), 0);

    // asynchronous reset during CBSO
    out_ready_a = 0; start_a = 1; e0 = cyc + 1;
    push_pass(0, e0, 8, 12, 8, 0);
    @(negedge clk); start_a = 0;
    wait_to(e0 + 46);
    chk("ar_busy_before", int'(busy_a), 1);
    #1 reset = 1'b0;
    #1;
    chk_idle_a("ar");
    chk("ar_gos", int'(cbs_go_a) + int'(cbso_go_a) + int'(res_go_a), 0);
`ifdef CSP_SEQ_PERF_EN
    chk("ar_perf", int'(perf_a), 0);
`endif
    #1 reset = 1'b1;
    start_a = 1; out_ready_a = 1; e0 = cyc + 1;
    push_pass(0, e0, 8, 12, 8, 1);
    @(negedge clk); start_a = 0;
    wait_to(e0 + 53);
    chk("ar_pass_done", int'(busy_a), 0);
    chk("ar_valid_low", int'(out_valid_a), 0);

    repeat (2) @(negedge clk);
    chk("q_empty_a", expq[0].size(), 0);
    chk("q_empty_b", expq[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
